// File: rtl/dispatch_arbiter_pkg.sv
// Shared types and defaults for the dispatch arbiter.
// Scoreboard count, function-unit encoding, credit sizing.
package dispatch_arbiter_pkg;

  localparam int SCOREBOARD_SIZE = 8;
  localparam int DISPATCH_N_FU = 4;
  localparam int DISPATCH_FU_CREDITS = 2;
  localparam int DISPATCH_CREDIT_W =
    $clog2(DISPATCH_FU_CREDITS + 1);

  typedef logic [$clog2(SCOREBOARD_SIZE)-1:0] RsvID_t;
  typedef logic [$clog2(DISPATCH_N_FU)-1:0] FuncUnitType_t;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispatch_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Ports: req, ptr in; gnt (one-hot), idx, valid out.
module rr_picker
  import dispatch_arbiter_pkg::*;
#(
  parameter int N = SCOREBOARD_SIZE,
  parameter int W = idxW(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        gnt[j] = 1'b1;
        idx = W'(j);
      end
    end
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// Round-robin dispatch arbiter with per-FU credits and a one-entry
// issue register. Ports: clk, rst (sync, active-high); sbReady,
// sbFuncUnit in; dispatchAck out; issueValid/issueSbId/issueFuncUnit
// out, issueAccept in; fuCreditReturn in; perfDispatchCnt,
// perfStallCnt out (live only with DISPATCH_PERF_CNT_EN, else 0).
module dispatch_arbiter
  import dispatch_arbiter_pkg::*;
#(
  parameter int N_SB = SCOREBOARD_SIZE,
  parameter int N_FU = DISPATCH_N_FU,
  parameter int FU_CREDITS = DISPATCH_FU_CREDITS,
  parameter int SB_W = idxW(N_SB),
  parameter int FU_W = idxW(N_FU)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SB-1:0]           sbReady,
  input  logic [N_SB-1:0][FU_W-1:0] sbFuncUnit,
  output logic [N_SB-1:0]           dispatchAck,
  output logic                      issueValid,
  output logic [SB_W-1:0]           issueSbId,
  output logic [FU_W-1:0]           issueFuncUnit,
  input  logic                      issueAccept,
  input  logic [N_FU-1:0]           fuCreditReturn,
  output logic [31:0]               perfDispatchCnt,
  output logic [31:0]               perfStallCnt
);

  localparam int CW = $clog2(FU_CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(FU_CREDITS);

  logic [CW-1:0]   credit [N_FU];
  logic [CW-1:0]   creditNext [N_FU];
  logic [N_SB-1:0] lastGrant;
  logic [N_SB-1:0] elig;
  logic [N_SB-1:0] pickGnt;
  logic [SB_W-1:0] rrPtr;
  logic [SB_W-1:0] pickIdx;
  logic [FU_W-1:0] winFu;
  logic            pickValid;
  logic            canLoad;
  logic            grant;

  // lastGrant masks a scoreboard whose Ready lags its ack by a cycle.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SB; i++) begin
      elig[i] = sbReady[i] && !lastGrant[i]
        && (credit[sbFuncUnit[i]] != '0);
    end
  end

  rr_picker #(
    .N(N_SB),
    .W(SB_W)
  ) uPicker (
    .req  (elig),
    .ptr  (rrPtr),
    .gnt  (pickGnt),
    .idx  (pickIdx),
    .valid(pickValid)
  );

  assign canLoad = !issueValid || issueAccept;
  assign grant = canLoad && pickValid;
  assign dispatchAck = grant ? pickGnt : '0;
  assign winFu = sbFuncUnit[pickIdx];

  // Grant and return on the same unit cancel; returns saturate.
  always_comb begin
    for (int f = 0; f < N_FU; f++) begin
      creditNext[f] = credit[f];
      if (grant && winFu == FU_W'(f)) begin
        if (!fuCreditReturn[f])
          creditNext[f] = credit[f] - 1'b1;
      end else if (fuCreditReturn[f]) begin
        if (credit[f] != CMAX)
          creditNext[f] = credit[f] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issueValid <= 1'b0;
      issueSbId <= '0;
      issueFuncUnit <= '0;
      rrPtr <= '0;
      lastGrant <= '0;
      for (int f = 0; f < N_FU; f++)
        credit[f] <= CMAX;
    end else begin
      lastGrant <= dispatchAck;
      if (grant) begin
        issueValid <= 1'b1;
        issueSbId <= pickIdx;
        issueFuncUnit <= winFu;
        rrPtr <= (pickIdx == SB_W'(N_SB - 1))
          ? '0 : pickIdx + SB_W'(1);
      end else if (issueAccept) begin
        issueValid <= 1'b0;
      end
      for (int f = 0; f < N_FU; f++)
        credit[f] <= creditNext[f];
    end
  end

  for (genvar f = 0; f < N_FU; f++) begin : gOvf
    aCreditOvf: assert property (
      @(posedge clk) disable iff (rst)
      !(fuCreditReturn[f] && credit[f] == CMAX));
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] dispCnt;
  logic [31:0] stallCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      dispCnt <= '0;
      stallCnt <= '0;
    end else begin
      if (grant)
        dispCnt <= dispCnt + 32'd1;
      if (|sbReady && !grant)
        stallCnt <= stallCnt + 32'd1;
    end
  end

  assign perfDispatchCnt = dispCnt;
  assign perfStallCnt = stallCnt;
`else
  assign perfDispatchCnt = '0;
  assign perfStallCnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_arbiter.sv
// Self-checking bench for dispatch_arbiter: vector table plus
// an issue scoreboard queue; default parameters.
module tb_dispatch_arbiter;
  import dispatch_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [7:0]       sbReady;
  logic [7:0][1:0]  sbFuncUnit;
  logic [7:0]       dispatchAck;
  logic             issueValid;
  logic [2:0]       issueSbId;
  logic [1:0]       issueFuncUnit;
  logic             issueAccept;
  logic [3:0]       fuCreditReturn;
  logic [31:0]      perfDispatchCnt;
  logic [31:0]      perfStallCnt;

  dispatch_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .sbReady        (sbReady),
    .sbFuncUnit     (sbFuncUnit),
    .dispatchAck    (dispatchAck),
    .issueValid     (issueValid),
    .issueSbId      (issueSbId),
    .issueFuncUnit  (issueFuncUnit),
    .issueAccept    (issueAccept),
    .fuCreditReturn (fuCreditReturn),
    .perfDispatchCnt(perfDispatchCnt),
    .perfStallCnt   (perfStallCnt)
  );

  typedef struct {
    logic            rst;
    logic [7:0]      ready;
    logic [7:0][1:0] fu;
    logic            acc;
    logic [3:0]      ret;
    logic [7:0]      expAck;
  } vec_t;

  typedef struct packed {
    logic [2:0] id;
    logic [1:0] fu;
  } iss_t;

  localparam logic [7:0][1:0] FA = '0;
  localparam logic [7:0][1:0] FM = {2'd3, 2'd2, 2'd1, 2'd0,
                                    2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [7:0][1:0] FD = {2'd3, 2'd2, 2'd1, 2'd0,
                                    2'd2, 2'd2, 2'd1, 2'd0};

  vec_t tbl[$];
  iss_t sbq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [7:0] rd,
                              input logic [7:0][1:0] fu,
                              input logic a, input logic [3:0] rt,
                              input logic [7:0] ea);
    vec_t v;
    v.rst = r;
    v.ready = rd;
    v.fu = fu;
    v.acc = a;
    v.ret = rt;
    v.expAck = ea;
    return v;
  endfunction

  initial begin
    vec_t v;
    iss_t e;
    int idx;
    logic expV;
    logic [2:0] expId;
    logic [1:0] expFu;
    int expDisp;
    int expStall;

    // sb2/sb5 on FU0: two grants then credit-starved
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h0, 8'h04));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h0, 8'h20));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h1, 8'h00));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h0, 8'h04));
    tbl.push_back(mk(0, 8'h24, FA, 1, 4'h1, 8'h00));
    tbl.push_back(mk(0, 8'h00, FA, 1, 4'h1, 8'h00));
    // move pointer to 6, then wrap 6,7,0,1
    tbl.push_back(mk(0, 8'h20, FM, 1, 4'h0, 8'h20));
    tbl.push_back(mk(0, 8'hFF, FM, 1, 4'h2, 8'h40));
    tbl.push_back(mk(0, 8'hFF, FM, 1, 4'h0, 8'h80));
    tbl.push_back(mk(0, 8'hFF, FM, 1, 4'h0, 8'h01));
    tbl.push_back(mk(0, 8'hFF, FM, 1, 4'h0, 8'h02));
    tbl.push_back(mk(0, 8'h00, FM, 1, 4'hF, 8'h00));
    // backpressure on sb1
    tbl.push_back(mk(0, 8'h02, FM, 0, 4'h0, 8'h02));
    tbl.push_back(mk(0, 8'h02, FM, 0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h02, FM, 0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h02, FM, 0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h02, FM, 1, 4'h0, 8'h02));
    tbl.push_back(mk(0, 8'h00, FM, 1, 4'h2, 8'h00));
    tbl.push_back(mk(0, 8'h00, FM, 1, 4'h2, 8'h00));
    // FU2 drained, return latency; FU1 grant+return cancel
    tbl.push_back(mk(0, 8'h04, FD, 1, 4'h0, 8'h04));
    tbl.push_back(mk(0, 8'h40, FD, 1, 4'h0, 8'h40));
    tbl.push_back(mk(0, 8'h08, FD, 1, 4'h4, 8'h00));
    tbl.push_back(mk(0, 8'h08, FD, 1, 4'h0, 8'h08));
    tbl.push_back(mk(0, 8'h20, FD, 1, 4'h4, 8'h20));
    tbl.push_back(mk(0, 8'h02, FD, 1, 4'h6, 8'h02));
    tbl.push_back(mk(0, 8'h22, FD, 1, 4'h0, 8'h20));
    tbl.push_back(mk(0, 8'h02, FD, 1, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h00, FD, 1, 4'h2, 8'h00));
    tbl.push_back(mk(0, 8'h00, FD, 1, 4'h2, 8'h00));
    // reset while holding an op with credit[0]=0
    tbl.push_back(mk(0, 8'h01, FM, 1, 4'h0, 8'h01));
    tbl.push_back(mk(0, 8'h10, FM, 1, 4'h0, 8'h10));
    tbl.push_back(mk(1, 8'h00, FM, 0, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'hFF, FA, 1, 4'h0, 8'h01));
    tbl.push_back(mk(0, 8'hFF, FA, 1, 4'h0, 8'h02));
    tbl.push_back(mk(0, 8'hFF, FA, 1, 4'h0, 8'h00));
    tbl.push_back(mk(0, 8'h00, FA, 1, 4'h1, 8'h00));
    tbl.push_back(mk(0, 8'h00, FA, 1, 4'h1, 8'h00));

    rst = 1'b1;
    sbReady = '0;
    sbFuncUnit = '0;
    issueAccept = 1'b0;
    fuCreditReturn = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(issueValid), 32'd0);
    chk("rst sbid", 32'(issueSbId), 32'd0);
    chk("rst fu", 32'(issueFuncUnit), 32'd0);
    chk("rst ack", 32'(dispatchAck), 32'd0);
    chk("rst perfD", perfDispatchCnt, 32'd0);
    chk("rst perfS", perfStallCnt, 32'd0);

    expV = 1'b0;
    expId = '0;
    expFu = '0;
    expDisp = 0;
    expStall = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(negedge clk);
      rst = v.rst;
      sbReady = v.ready;
      sbFuncUnit = v.fu;
      issueAccept = v.acc;
      fuCreditReturn = v.ret;
      #1;
      chk($sformatf("v%0d ack", i), 32'(dispatchAck),
          32'(v.expAck));
      if (v.expAck != 0 && !v.rst) begin
        idx = 0;
        for (int b = 0; b < 8; b++)
          if (v.expAck[b]) idx = b;
        e.id = 3'(idx);
        e.fu = v.fu[idx];
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (v.rst) begin
        expV = 1'b0;
        expId = '0;
        expFu = '0;
        sbq.delete();
        expDisp = 0;
        expStall = 0;
      end else if (v.expAck != 0) begin
        e = sbq.pop_front();
        expV = 1'b1;
        expId = e.id;
        expFu = e.fu;
        expDisp++;
      end else begin
        if (v.acc) expV = 1'b0;
        if (|v.ready) expStall++;
      end
      chk($sformatf("v%0d valid", i), 32'(issueValid), 32'(expV));
      if (expV || v.rst) begin
        chk($sformatf("v%0d sbid", i), 32'(issueSbId), 32'(expId));
        chk($sformatf("v%0d fu", i), 32'(issueFuncUnit),
            32'(expFu));
      end
`ifdef DISPATCH_PERF_CNT_EN
      chk($sformatf("v%0d perfD", i), perfDispatchCnt,
          32'(expDisp));
      chk($sformatf("v%0d perfS", i), perfStallCnt,
          32'(expStall));
`else
      chk($sformatf("v%0d perfD", i), perfDispatchCnt, 32'd0);
      chk($sformatf("v%0d perfS", i), perfStallCnt, 32'd0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
